// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer for the instruction ROM.
// Sequences IDLE -> RUN -> DONE with branches and stalls, and counts retired instructions.
module fetch_sequencer #(
   parameter int A  = 16,
   parameter int W  = 9,
   parameter int OW = 8
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          Start,
   input  logic [A-1:0]  StartAddr,
   input  logic          Stall,
   input  logic          Halt,
   input  logic          BranchAbs,
   input  logic [A-1:0]  Target,
   input  logic          BranchRel,
   input  logic [OW-1:0] Offset,
   input  logic [W-1:0]  InstIn,
   output logic [A-1:0]  InstAddress,
   output logic [W-1:0]  InstOut,
   output logic          InstValid,
   output logic          Done,
   output logic [A-1:0]  InstCount
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [A-1:0]  pc;
   logic [A-1:0]  count;
   logic          done_q;
   logic [A-1:0]  offset_ext;
   logic [A-1:0]  count_inc;

   assign offset_ext = A'($signed(Offset));
   // The retired-instruction count sticks at all-ones instead of wrapping.
   assign count_inc  = (count == '1) ? count : count + A'(1);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state  <= IDLE;
         pc     <= '0;
         count  <= '0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state  <= RUN;
                  pc     <= StartAddr;
                  count  <= '0;
                  done_q <= 1'b0;
               end
            end
            RUN: begin
               // A stall freezes everything, so halt and branches wait too.
               if (!Stall) begin
                  count <= count_inc;
                  if (Halt) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else if (BranchAbs) begin
                     pc <= Target;
                  end else if (BranchRel) begin
                     pc <= pc + offset_ext;
                  end else begin
                     pc <= pc + A'(1);
                  end
               end
            end
            default: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign InstAddress = pc;
   assign InstCount   = count;
   assign InstOut     = InstIn;
   assign Done        = done_q;
   assign InstValid   = (state == RUN) && !Stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural model checked every cycle,
// plus directed literal checks; a narrow second instance exercises count saturation.
module tb_fetch_sequencer;

   typedef struct {
      int mode;   // 0 idle, 1 run, 2 done
      int pc;
      int cnt;
   } mstate_t;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [15:0] StartAddr = '0;
   logic        Stall = 1'b0;
   logic        Halt = 1'b0;
   logic        BranchAbs = 1'b0;
   logic [15:0] Target = '0;
   logic        BranchRel = 1'b0;
   logic [7:0]  Offset = '0;
   logic [8:0]  InstIn = '0;
   logic [15:0] InstAddress;
   logic [8:0]  InstOut;
   logic        InstValid;
   logic        Done;
   logic [15:0] InstCount;

   logic        s_start = 1'b0;
   logic [3:0]  s_saddr = '0;
   logic        s_stall = 1'b0;
   logic        s_halt = 1'b0;
   logic        s_babs = 1'b0;
   logic [3:0]  s_target = '0;
   logic        s_brel = 1'b0;
   logic [3:0]  s_offset = '0;
   logic [8:0]  s_inst_in = 9'h1A5;
   logic [3:0]  s_addr;
   logic [8:0]  s_inst_out;
   logic        s_valid;
   logic        s_done;
   logic [3:0]  s_count;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;
   mstate_t mm = '{0, 0, 0};
   mstate_t ms = '{0, 0, 0};

   fetch_sequencer #(.A(16), .W(9), .OW(8)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
      .Stall(Stall), .Halt(Halt), .BranchAbs(BranchAbs), .Target(Target),
      .BranchRel(BranchRel), .Offset(Offset), .InstIn(InstIn),
      .InstAddress(InstAddress), .InstOut(InstOut), .InstValid(InstValid),
      .Done(Done), .InstCount(InstCount)
   );

   fetch_sequencer #(.A(4), .W(9), .OW(4)) small_dut (
      .CLK(CLK), .Reset(Reset), .Start(s_start), .StartAddr(s_saddr),
      .Stall(s_stall), .Halt(s_halt), .BranchAbs(s_babs), .Target(s_target),
      .BranchRel(s_brel), .Offset(s_offset), .InstIn(s_inst_in),
      .InstAddress(s_addr), .InstOut(s_inst_out), .InstValid(s_valid),
      .Done(s_done), .InstCount(s_count)
   );

   always #5 CLK = ~CLK;

   // Next architectural state from the written rules, using plain integer arithmetic.
   function automatic mstate_t model_step(mstate_t s, bit rst, bit start, int saddr,
                                          bit stall, bit halt, bit babs, int tgt,
                                          bit brel, int off, int a, int ow);
      mstate_t n = s;
      int mask = (1 << a) - 1;
      int soff;
      if (rst) begin
         n.mode = 0; n.pc = 0; n.cnt = 0;
      end else if (s.mode != 1) begin
         if (start) begin
            n.mode = 1; n.pc = saddr; n.cnt = 0;
         end
      end else if (!stall) begin
         n.cnt = (s.cnt >= mask) ? mask : s.cnt + 1;
         if (halt) n.mode = 2;
         else if (babs) n.pc = tgt;
         else if (brel) begin
            soff = (off >= (1 << (ow - 1))) ? off - (1 << ow) : off;
            n.pc = (s.pc + soff) & mask;
         end else n.pc = (s.pc + 1) & mask;
      end
      return n;
   endfunction

   always @(posedge CLK) begin
      mm = model_step(mm, Reset, Start, int'(StartAddr), Stall, Halt, BranchAbs,
                      int'(Target), BranchRel, int'(Offset), 16, 8);
      ms = model_step(ms, Reset, s_start, int'(s_saddr), s_stall, s_halt, s_babs,
                      int'(s_target), s_brel, int'(s_offset), 4, 4);
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every cycle, compare both instances against the model away from the clock edge.
   always @(negedge CLK) begin
      if (check_en) begin
         checkOutput("m_addr",  int'(InstAddress), mm.pc);
         checkOutput("m_count", int'(InstCount), mm.cnt);
         checkOutput("m_valid", int'(InstValid), int'(mm.mode == 1 && !Stall));
         checkOutput("m_done",  int'(Done), int'(mm.mode == 2));
         if (InstValid) checkOutput("m_inst", int'(InstOut), int'(InstIn));
         checkOutput("s_addr",  int'(s_addr), ms.pc);
         checkOutput("s_count", int'(s_count), ms.cnt);
         checkOutput("s_valid", int'(s_valid), int'(ms.mode == 1 && !s_stall));
         checkOutput("s_done",  int'(s_done), int'(ms.mode == 2));
      end
   end

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #2;
         InstIn = 9'($urandom);
      end
   endtask

   int saved;

   initial begin
      $display("[TB] starting fetch_sequencer bench");
      applyStimulus(2);
      Reset = 1'b0;
      check_en = 1'b1;
      #1;
      checkOutput("reset_addr", int'(InstAddress), 0);
      checkOutput("reset_count", int'(InstCount), 0);
      checkOutput("reset_done", int'(Done), 0);
      checkOutput("reset_valid", int'(InstValid), 0);

      Start = 1'b1; StartAddr = 16'h0010;
      applyStimulus(1);
      Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("seq_addr", int'(InstAddress), 16'h0010 + i);
         checkOutput("seq_count", int'(InstCount), i);
         checkOutput("seq_valid", int'(InstValid), 1);
         applyStimulus(1);
      end

      BranchAbs = 1'b1; Target = 16'h0020;
      applyStimulus(1);
      BranchAbs = 1'b0; BranchRel = 1'b1; Offset = 8'hFC;
      applyStimulus(1);
      checkOutput("rel_back", int'(InstAddress), 16'h001C);
      Offset = 8'h05;
      applyStimulus(1);
      checkOutput("rel_fwd", int'(InstAddress), 16'h0021);
      checkOutput("model_rel", mm.pc, 16'h0021);
      BranchRel = 1'b0;

      BranchAbs = 1'b1; Target = 16'h0030;
      applyStimulus(1);
      Target = 16'h0100; BranchRel = 1'b1; Offset = 8'h05;
      applyStimulus(1);
      checkOutput("abs_wins", int'(InstAddress), 16'h0100);
      BranchRel = 1'b0; Target = 16'hFFFF;
      applyStimulus(1);
      BranchAbs = 1'b0;
      applyStimulus(1);
      checkOutput("pc_wrap", int'(InstAddress), 16'h0000);

      BranchAbs = 1'b1; Target = 16'h0042;
      applyStimulus(1);
      saved = int'(InstCount);
      Stall = 1'b1; Halt = 1'b1; Target = 16'h0099;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("stall_valid", int'(InstValid), 0);
         applyStimulus(1);
         checkOutput("stall_addr", int'(InstAddress), 16'h0042);
         checkOutput("stall_count", int'(InstCount), saved);
         checkOutput("stall_done", int'(Done), 0);
      end
      Stall = 1'b0; BranchAbs = 1'b0;
      applyStimulus(1);
      Halt = 1'b0;
      #1;
      checkOutput("halt_done", int'(Done), 1);
      checkOutput("halt_addr", int'(InstAddress), 16'h0042);
      checkOutput("halt_count", int'(InstCount), saved + 1);
      checkOutput("halt_valid", int'(InstValid), 0);
      applyStimulus(2);
      checkOutput("done_hold", int'(Done), 1);

      Start = 1'b1; StartAddr = 16'h0005;
      applyStimulus(1);
      Start = 1'b0;
      checkOutput("restart_addr", int'(InstAddress), 16'h0005);
      checkOutput("restart_count", int'(InstCount), 0);
      checkOutput("restart_done", int'(Done), 0);
      applyStimulus(1);
      Start = 1'b1; StartAddr = 16'h0200;
      applyStimulus(1);
      Start = 1'b0;
      checkOutput("start_in_run", int'(InstAddress), 16'h0007);

      BranchAbs = 1'b1; Target = 16'h0077;
      applyStimulus(1);
      BranchAbs = 1'b0; Reset = 1'b1; Stall = 1'b1;
      applyStimulus(1);
      Reset = 1'b0; Stall = 1'b0;
      #1;
      checkOutput("midreset_addr", int'(InstAddress), 0);
      checkOutput("midreset_count", int'(InstCount), 0);
      checkOutput("midreset_done", int'(Done), 0);
      checkOutput("midreset_valid", int'(InstValid), 0);
      applyStimulus(2);
      checkOutput("idle_stays", int'(InstAddress), 0);

      s_start = 1'b1; s_saddr = 4'h3;
      applyStimulus(1);
      s_start = 1'b0;
      applyStimulus(5);
      s_brel = 1'b1; s_offset = 4'hE;
      applyStimulus(1);
      s_brel = 1'b0;
      applyStimulus(14);
      checkOutput("sat_count", int'(s_count), 15);
      applyStimulus(3);
      checkOutput("sat_hold", int'(s_count), 15);
      s_halt = 1'b1;
      applyStimulus(1);
      s_halt = 1'b0;
      checkOutput("sat_halt_count", int'(s_count), 15);
      checkOutput("sat_halt_done", int'(s_done), 1);
      applyStimulus(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
